// File: rtl/fetch_unit.sv
// fetch_unit: RV64 fetch stage; holds fetch PC, issues 32-bit imem reads, buffers {instr, pc} for decode.
// Latency: imem_rvalid -> instr_valid 1 cycle (registered, no bypass); redirect takes effect next cycle.
// Backpressure: instr_ready=0 fills the buffer; imem_req drops once outstanding + buffered == FIFO_DEPTH.
//
// Ports:
//   clk, rst_n                      core clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt     fetch request, word-aligned address, acceptance
//   imem_rvalid/imem_rdata          in-order read responses
//   redirect/redirect_pc            taken control transfer pulse and new fetch address
//   instr_valid/instr_ready         decode handshake; instr/pc_addr = head entry (NOP/0 when empty)
//   fetch_misaligned                only with IFU_MISALIGN_EXC_EN: misaligned redirect target seen
//
// Optional feature macro: IFU_MISALIGN_EXC_EN. When undefined, redirect_pc[1:0] is forced to zero.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] pc_addr
`ifdef IFU_MISALIGN_EXC_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

`ifdef IFU_MISALIGN_EXC_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
`else
  typedef enum logic [0:0] {BOOT, RUN} state_t;
`endif

  state_t state, state_nxt;

  logic [63:0]   fpc, fpc_nxt;
  logic [CW-1:0] outstanding, outs_nxt;
  logic [CW-1:0] drop_cnt, drop_nxt;
  logic [CW:0]   used;
  logic          hs, rv, push, pop;

  // PC shadow queue: one entry per granted request, popped by every counted
  // response (kept or dropped), so its occupancy is the outstanding count.
  logic [63:0]   pq_mem [FIFO_DEPTH];
  logic [AW-1:0] pq_wr, pq_rd;

  // Instruction buffer presented to decode.
  entry_t        iq_mem [FIFO_DEPTH];
  logic [AW-1:0] iq_wr, iq_rd;
  logic [CW-1:0] iq_cnt;
  entry_t        head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    state_nxt   = state;
    used        = {1'b0, outstanding} + {1'b0, iq_cnt};
    imem_req    = 1'b0;
    imem_addr   = fpc;
    hs          = 1'b0;
    rv          = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    instr_valid = 1'b0;
    head        = iq_mem[iq_rd];
    instr       = NOP;
    pc_addr     = '0;

    if (state == BOOT) state_nxt = RUN;
`ifdef IFU_MISALIGN_EXC_EN
    if (redirect) state_nxt = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`endif

    // Requests are suppressed in the redirect cycle, so a grant can never
    // coincide with a redirect; anything granted earlier is still in flight
    // and gets dropped below.
    imem_req = (state == RUN) && !redirect && (used < LIMIT);
    hs       = imem_req && imem_gnt;
    // A response with nothing outstanding (e.g. straddling reset) is ignored.
    rv       = imem_rvalid && (outstanding != '0);
    push     = rv && (drop_cnt == '0) && !redirect;

    instr_valid = (iq_cnt != '0);
    pop         = instr_valid && instr_ready && !redirect;
    if (instr_valid) begin
      instr   = head.instr;
      pc_addr = head.pc;
    end

    outs_nxt = outstanding + CW'(hs) - CW'(rv);
    // drop_cnt never exceeds outstanding, so after a redirect every request
    // still in flight is exactly the set to discard.
    if (redirect) drop_nxt = outs_nxt;
    else          drop_nxt = drop_cnt - CW'(rv && (drop_cnt != '0));

    if (redirect) fpc_nxt = redirect_pc & ~64'h3;
    else if (hs)  fpc_nxt = fpc + 64'd4;
    else          fpc_nxt = fpc;
  end

`ifdef IFU_MISALIGN_EXC_EN
  assign fetch_misaligned = (state == FAULT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fpc         <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      iq_wr       <= '0;
      iq_rd       <= '0;
      iq_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      fpc         <= fpc_nxt;
      outstanding <= outs_nxt;
      drop_cnt    <= drop_nxt;
      if (hs) pq_wr <= ptr_inc(pq_wr);
      if (rv) pq_rd <= ptr_inc(pq_rd);
      if (redirect) begin
        iq_wr  <= '0;
        iq_rd  <= '0;
        iq_cnt <= '0;
      end else begin
        if (push) iq_wr <= ptr_inc(iq_wr);
        if (pop)  iq_rd <= ptr_inc(iq_rd);
        iq_cnt <= iq_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (hs)   pq_mem[pq_wr] <= fpc;
    if (push) iq_mem[iq_wr] <= '{instr: imem_rdata, pc: pq_mem[pq_rd]};
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] pc_addr;
`ifdef IFU_MISALIGN_EXC_EN
  logic        fetch_misaligned;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instr(instr), .pc_addr(pc_addr)
`ifdef IFU_MISALIGN_EXC_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdr, input logic [63:0] rpc, input logic rdy);
    @(posedge clk); #1;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect = rdr; redirect_pc = rpc; instr_ready = rdy;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   imem_req,    0);
    chk({tag, "_addr"},  imem_addr,   64'h0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr,       NOP);
    chk({tag, "_pc"},    pc_addr,     64'h0);
  endtask

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[15:0]} ^ 32'h5A5A_0013;
  endfunction

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [63:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdr, input logic [63:0] rpc, input logic rdy,
                              input logic er, input logic [63:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [63:0] ep);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.redir = rdr; v.rpc = rpc; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  vec_t tbl[23];

  logic [63:0] inflight[$];
  logic [63:0] exp_req, exp_pop, tgt;
  logic        after_redir, prev_redir;
  int          pops;

  initial begin
    //             gnt rv rdata          rdr rpc      rdy | req addr     v  instr          pc
    tbl[0]  = mk(1, 0, 32'h0,         0, 64'h0,   1,  0, 64'h0,   0, NOP,           64'h0);
    tbl[1]  = mk(1, 0, 32'h0,         0, 64'h0,   1,  1, 64'h0,   0, NOP,           64'h0);
    tbl[2]  = mk(1, 1, 32'h0050_0093, 0, 64'h0,   1,  1, 64'h4,   0, NOP,           64'h0);
    tbl[3]  = mk(1, 1, 32'hD100_0001, 0, 64'h0,   0,  0, 64'h8,   1, 32'h0050_0093, 64'h0);
    tbl[4]  = mk(1, 0, 32'h0,         0, 64'h0,   0,  0, 64'h8,   1, 32'h0050_0093, 64'h0);
    tbl[5]  = mk(1, 0, 32'h0,         0, 64'h0,   0,  0, 64'h8,   1, 32'h0050_0093, 64'h0);
    tbl[6]  = mk(0, 0, 32'h0,         0, 64'h0,   1,  0, 64'h8,   1, 32'h0050_0093, 64'h0);
    tbl[7]  = mk(0, 0, 32'h0,         0, 64'h0,   1,  1, 64'h8,   1, 32'hD100_0001, 64'h4);
    tbl[8]  = mk(0, 0, 32'h0,         0, 64'h0,   1,  1, 64'h8,   0, NOP,           64'h0);
    tbl[9]  = mk(0, 0, 32'h0,         0, 64'h0,   1,  1, 64'h8,   0, NOP,           64'h0);
    tbl[10] = mk(1, 0, 32'h0,         0, 64'h0,   1,  1, 64'h8,   0, NOP,           64'h0);
    tbl[11] = mk(1, 0, 32'h0,         0, 64'h0,   1,  1, 64'hC,   0, NOP,           64'h0);
    tbl[12] = mk(1, 0, 32'h0,         1, 64'h100, 1,  0, 64'h10,  0, NOP,           64'h0);
    tbl[13] = mk(1, 1, 32'hDEAD_0001, 0, 64'h0,   1,  0, 64'h100, 0, NOP,           64'h0);
    tbl[14] = mk(1, 1, 32'hBEEF_0002, 0, 64'h0,   1,  1, 64'h100, 0, NOP,           64'h0);
    tbl[15] = mk(0, 1, 32'hD200_0002, 0, 64'h0,   1,  1, 64'h104, 0, NOP,           64'h0);
    tbl[16] = mk(0, 0, 32'h0,         0, 64'h0,   0,  1, 64'h104, 1, 32'hD200_0002, 64'h100);
    tbl[17] = mk(1, 0, 32'h0,         0, 64'h0,   0,  1, 64'h104, 1, 32'hD200_0002, 64'h100);
    tbl[18] = mk(1, 1, 32'hD300_0003, 1, 64'h200, 1,  0, 64'h108, 1, 32'hD200_0002, 64'h100);
    tbl[19] = mk(0, 0, 32'h0,         0, 64'h0,   1,  1, 64'h200, 0, NOP,           64'h0);
    tbl[20] = mk(0, 1, 32'hBAD0_0BAD, 0, 64'h0,   1,  1, 64'h200, 0, NOP,           64'h0);
    tbl[21] = mk(0, 0, 32'h0,         0, 64'h0,   1,  1, 64'h200, 0, NOP,           64'h0);
    tbl[22] = mk(1, 0, 32'h0,         0, 64'h0,   1,  1, 64'h200, 0, NOP,           64'h0);

    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect = 0; redirect_pc = '0; instr_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
`ifdef IFU_MISALIGN_EXC_EN
    chk("reset_misaligned", fetch_misaligned, 0);
`endif

    // Directed table: row 0 is the BOOT cycle right after release.
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc; instr_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d_req", i),   imem_req,    tbl[i].e_req);
      chk($sformatf("row%0d_addr", i),  imem_addr,   tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), instr_valid, tbl[i].e_valid);
      chk($sformatf("row%0d_instr", i), instr,       tbl[i].e_instr);
      chk($sformatf("row%0d_pc", i),    pc_addr,     tbl[i].e_pc);
    end

    // Reset pulsed mid-stream with a request outstanding; its late response is ignored.
    @(posedge clk); #1;
    imem_gnt = 0; imem_rvalid = 0; redirect = 0; instr_ready = 1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1; imem_rvalid = 1; imem_rdata = 32'hBAD0_0200;
    @(negedge clk);
    chk("boot_req", imem_req, 0);
    chk("boot_valid", instr_valid, 0);
    cyc(1, 0, 32'h0, 0, 64'h0, 1);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 64'h0);
    cyc(0, 1, 32'h0000_0011, 0, 64'h0, 1);
    chk("late_rsp_valid", instr_valid, 0);
    chk("restart_addr4", imem_addr, 64'h4);
    cyc(0, 0, 32'h0, 0, 64'h0, 0);
    chk("restart_valid", instr_valid, 1);
    chk("restart_instr", instr, 32'h0000_0011);
    chk("restart_pc", pc_addr, 64'h0);

`ifdef IFU_MISALIGN_EXC_EN
    cyc(0, 0, 32'h0, 1, 64'h102, 1);
    chk("mis_redir_req", imem_req, 0);
    chk("mis_flag_pre", fetch_misaligned, 0);
    cyc(1, 0, 32'h0, 0, 64'h0, 1);
    chk("mis_flag", fetch_misaligned, 1);
    chk("mis_req", imem_req, 0);
    chk("mis_valid", instr_valid, 0);
    cyc(1, 0, 32'h0, 0, 64'h0, 1);
    chk("mis_req_held", imem_req, 0);
    cyc(0, 0, 32'h0, 1, 64'h200, 1);
    chk("mis_fix_req", imem_req, 0);
    cyc(0, 0, 32'h0, 0, 64'h0, 1);
    chk("mis_flag_clr", fetch_misaligned, 0);
    chk("mis_resume_req", imem_req, 1);
    chk("mis_resume_addr", imem_addr, 64'h200);
`else
    cyc(0, 0, 32'h0, 1, 64'h307, 1);
    chk("mask_redir_req", imem_req, 0);
    cyc(1, 0, 32'h0, 0, 64'h0, 1);
    chk("mask_req", imem_req, 1);
    chk("mask_addr", imem_addr, 64'h304);
    chk("mask_flushed", instr_valid, 0);
    cyc(0, 0, 32'h0, 0, 64'h0, 0);
    chk("mask_addr_next", imem_addr, 64'h308);
    cyc(0, 1, 32'h0000_0077, 0, 64'h0, 0);
    chk("mask_lat_valid", instr_valid, 0);
    cyc(0, 0, 32'h0, 0, 64'h0, 0);
    chk("mask_valid", instr_valid, 1);
    chk("mask_pc", pc_addr, 64'h304);
    chk("mask_instr", instr, 32'h0000_0077);
`endif

    // Fetch PC wraps at the top of the address space.
    cyc(0, 0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    cyc(1, 0, 32'h0, 0, 64'h0, 1);
    chk("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 32'h0, 0, 64'h0, 1);
    chk("wrap_addr_zero", imem_addr, 64'h0);

    // Random phase: fresh reset, then scoreboard against the program-order rule.
    @(posedge clk); #1;
    imem_gnt = 0; imem_rvalid = 0; redirect = 0; instr_ready = 0;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    inflight.delete();
    exp_req = 64'h0; exp_pop = 64'h0;
    after_redir = 0; prev_redir = 0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      imem_gnt    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = !prev_redir && ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0;
      else                           tgt = {46'h0, 16'($urandom), 2'b00};
      redirect_pc = tgt;
      if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(inflight.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      @(negedge clk);
      if (after_redir) chk("rnd_valid_after_redirect", instr_valid, 0);
      if (!instr_valid) begin
        chk("rnd_idle_instr", instr, NOP);
        chk("rnd_idle_pc", pc_addr, 64'h0);
      end
      if (redirect) begin
        chk("rnd_req_in_redirect", imem_req, 0);
        exp_req = tgt;
        exp_pop = tgt;
      end else begin
        if (imem_req && imem_gnt) begin
          chk("rnd_req_addr", imem_addr, exp_req);
          inflight.push_back(exp_req);
          exp_req = exp_req + 64'd4;
          chk("rnd_credit", (inflight.size() <= DEPTH), 1);
        end
        if (instr_valid && instr_ready) begin
          chk("rnd_pop_pc", pc_addr, exp_pop);
          chk("rnd_pop_instr", instr, mem_word(exp_pop));
          exp_pop = exp_pop + 64'd4;
          pops++;
        end
      end
      after_redir = redirect;
      prev_redir  = redirect;
    end
    chk("rnd_progress", (pops >= 200), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
